pixel_write_arbiter: RTL and testbench

//  Sole owner of the pixel_memory write port (write_en/x/y/color) feeding the LED

---
 rtl/pixel_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: sole owner of the pixel_memory write port. Arbitrates
// two pixel requesters round-robin and runs a full-frame clear sweep that
// fills all pixels with one colour. Outputs are registered, one write per clk.
module pixel_write_arbiter #(
  parameter int COLOR_W = 12,
  parameter int COORD_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [COORD_W-1:0] req0_x,
  input  logic [COORD_W-1:0] req0_y,
  input  logic [COLOR_W-1:0] req0_color,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [COORD_W-1:0] req1_x,
  input  logic [COORD_W-1:0] req1_y,
  input  logic [COLOR_W-1:0] req1_color,
  output logic               write_en,
  output logic [COORD_W-1:0] write_x,
  output logic [COORD_W-1:0] write_y,
  output logic [COLOR_W-1:0] write_color
);

  localparam int CTR_W = 2 * COORD_W;
  localparam logic [CTR_W-1:0] LAST_PIX = '1;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;          // pixel index currently on the write port during a sweep
  logic [COLOR_W-1:0] fill_q, fill_d;        // colour captured at clear_start
  logic               last_grant_q, last_grant_d;  // 1 = req1 won the last contended cycle
  logic               write_en_q, write_en_d;
  logic [COORD_W-1:0] write_x_q, write_x_d;
  logic [COORD_W-1:0] write_y_q, write_y_d;
  logic [COLOR_W-1:0] write_color_q, write_color_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, arbitration and combinational ready generation
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    fill_d        = fill_q;
    last_grant_d  = last_grant_q;
    write_en_d    = 1'b0;
    write_x_d     = write_x_q;
    write_y_d     = write_y_q;
    write_color_d = write_color_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;

    case (state_q)
      ARB: begin
        if (clear_start) begin
          // First sweep write (0,0) goes out on the very next cycle.
          state_d       = CLEAR;
          ctr_d         = '0;
          fill_d        = clear_color;
          busy_d        = 1'b1;
          write_en_d    = 1'b1;
          write_x_d     = '0;
          write_y_d     = '0;
          write_color_d = clear_color;
        end else begin
          if (req0_valid && req1_valid) begin
            // Contention: the side that did not win last time gets the port.
            req0_ready   = last_grant_q;
            req1_ready   = ~last_grant_q;
            last_grant_d = ~last_grant_q;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
          if (req0_ready) begin
            write_en_d    = 1'b1;
            write_x_d     = req0_x;
            write_y_d     = req0_y;
            write_color_d = req0_color;
          end else if (req1_ready) begin
            write_en_d    = 1'b1;
            write_x_d     = req1_x;
            write_y_d     = req1_y;
            write_color_d = req1_color;
          end
        end
      end
      CLEAR: begin
        if (ctr_q == LAST_PIX) begin
          // Final pixel is on the port now; hand back to arbitration next cycle.
          state_d = ARB;
          ctr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ctr_d         = ctr_q + CTR_ONE;
          write_en_d    = 1'b1;
          write_x_d     = ctr_d[COORD_W-1:0];
          write_y_d     = ctr_d[CTR_W-1:COORD_W];
          write_color_d = fill_q;
          done_d        = (ctr_d == LAST_PIX);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB;
      ctr_q         <= '0;
      fill_q        <= '0;
      last_grant_q  <= 1'b1;
      write_en_q    <= 1'b0;
      write_x_q     <= '0;
      write_y_q     <= '0;
      write_color_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      fill_q        <= fill_d;
      last_grant_q  <= last_grant_d;
      write_en_q    <= write_en_d;
      write_x_q     <= write_x_d;
      write_y_q     <= write_y_d;
      write_color_q <= write_color_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign write_en    = write_en_q;
  assign write_x     = write_x_q;
  assign write_y     = write_y_q;
  assign write_color = write_color_q;
  assign clear_busy  = busy_q;
  assign clear_done  = done_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Testbench for pixel_write_arbiter: directed table, clear-sweep sequences,
// async reset mid-sweep, and randomized traffic against a reference model.
module tb_pixel_write_arbiter;

  logic        clk;
  logic        reset;
  logic        clear_start;
  logic [11:0] clear_color;
  logic        clear_busy, clear_done;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_x, req0_y, req1_x, req1_y;
  logic [11:0] req0_color, req1_color;
  logic        write_en;
  logic [5:0]  write_x, write_y;
  logic [11:0] write_color;

  pixel_write_arbiter #(.COLOR_W(12), .COORD_W(6)) dut (
    .clk(clk), .reset(reset),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_color(req0_color),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_color(req1_color),
    .write_en(write_en), .write_x(write_x), .write_y(write_y),
    .write_color(write_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [11:0] c;
  } pix_t;

  pix_t        m_q[$];       // pending sweep writes
  logic        m_in_clear;   // write port currently carries sweep pixels
  int          m_last;       // index of the last contended winner
  logic        m_en, m_busy, m_done;
  logic [5:0]  m_x, m_y;
  logic [11:0] m_c;
  logic        e_r0, e_r1;

  function automatic void model_reset();
    m_q.delete();
    m_in_clear = 1'b0;
    m_last = 1;
    m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_x = '0; m_y = '0; m_c = '0;
    e_r0 = 1'b0; e_r1 = 1'b0;
  endfunction

  // Evaluated just before a rising edge: expected ready now, outputs after the edge.
  function automatic void model_pre();
    pix_t p;
    int g;
    e_r0 = 1'b0; e_r1 = 1'b0; m_en = 1'b0; m_done = 1'b0;
    if (m_in_clear) begin
      if (m_q.size() > 0) begin
        p = m_q.pop_front();
        m_en = 1'b1; m_x = p.x; m_y = p.y; m_c = p.c;
        m_done = (m_q.size() == 0);
      end else begin
        m_in_clear = 1'b0;
        m_busy = 1'b0;
      end
    end else if (clear_start) begin
      for (int yy = 0; yy < 64; yy++)
        for (int xx = 0; xx < 64; xx++) begin
          p.x = 6'(xx); p.y = 6'(yy); p.c = clear_color;
          m_q.push_back(p);
        end
      p = m_q.pop_front();
      m_en = 1'b1; m_x = p.x; m_y = p.y; m_c = p.c;
      m_in_clear = 1'b1;
      m_busy = 1'b1;
    end else begin
      g = -1;
      if (req0_valid && req1_valid) begin
        g = (m_last == 1) ? 0 : 1;
        m_last = g;
      end else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      if (g == 0) begin
        e_r0 = 1'b1; m_en = 1'b1; m_x = req0_x; m_y = req0_y; m_c = req0_color;
      end else if (g == 1) begin
        e_r1 = 1'b1; m_en = 1'b1; m_x = req1_x; m_y = req1_y; m_c = req1_color;
      end
    end
  endfunction

  int   n_wr, n_done, n_rdy;
  logic rdy0_s, rdy1_s;

  // One clock cycle: entered at posedge+1 with inputs set, leaves at posedge+1.
  task automatic step();
    #4;
    model_pre();
    rdy0_s = req0_ready;
    rdy1_s = req1_ready;
    if (req0_ready || req1_ready) n_rdy++;
    chk("ready", {rdy0_s, rdy1_s}, {e_r0, e_r1});
    @(posedge clk);
    #1;
    if (write_en) n_wr++;
    if (clear_done) n_done++;
    chk("write_port", {write_en, write_x, write_y, write_color},
        {m_en, m_x, m_y, m_c});
    chk("clear_flags", {clear_busy, clear_done}, {m_busy, m_done});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v0, v1;
    logic [5:0]  x0, y0, x1, y1;
    logic [11:0] c0, c1;
    logic        r0, r1, en;
    logic [5:0]  ex, ey;
    logic [11:0] ec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    reset = 1'b1; clear_start = 1'b0; clear_color = '0;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_color = '0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_color = '0;
    n_wr = 0; n_done = 0; n_rdy = 0; rdy0_s = 1'b0; rdy1_s = 1'b0;
    model_reset();

    tbl[0] = '{1,0, 6'd5,6'd7, 6'd0,6'd0, 12'hF00,12'h000, 1,0,1, 6'd5,6'd7, 12'hF00};
    tbl[1] = '{1,1, 6'd1,6'd2, 6'd3,6'd4, 12'h111,12'h222, 1,0,1, 6'd1,6'd2, 12'h111};
    tbl[2] = '{1,1, 6'd1,6'd2, 6'd3,6'd4, 12'h111,12'h222, 0,1,1, 6'd3,6'd4, 12'h222};
    tbl[3] = '{1,1, 6'd1,6'd2, 6'd3,6'd4, 12'h111,12'h222, 1,0,1, 6'd1,6'd2, 12'h111};
    tbl[4] = '{1,1, 6'd1,6'd2, 6'd3,6'd4, 12'h111,12'h222, 0,1,1, 6'd3,6'd4, 12'h222};
    tbl[5] = '{0,0, 6'd1,6'd2, 6'd3,6'd4, 12'h111,12'h222, 0,0,0, 6'd3,6'd4, 12'h222};
    tbl[6] = '{0,1, 6'd1,6'd2, 6'd9,6'd9, 12'h111,12'hABC, 0,1,1, 6'd9,6'd9, 12'hABC};
    tbl[7] = '{1,1, 6'd10,6'd20, 6'd9,6'd9, 12'h0F0,12'hABC, 1,0,1, 6'd10,6'd20, 12'h0F0};

    // Reset state
    @(posedge clk); #1;
    chk("reset_outputs", {write_en, write_x, write_y, write_color, clear_busy, clear_done}, '0);
    do_reset();
    chk("reset_release", {write_en, write_x, write_y, write_color, clear_busy, clear_done}, '0);

    for (int i = 0; i < 8; i++) begin
      req0_valid = tbl[i].v0; req0_x = tbl[i].x0; req0_y = tbl[i].y0; req0_color = tbl[i].c0;
      req1_valid = tbl[i].v1; req1_x = tbl[i].x1; req1_y = tbl[i].y1; req1_color = tbl[i].c1;
      #4;
      chk($sformatf("tbl%0d_ready", i), {req0_ready, req1_ready}, {tbl[i].r0, tbl[i].r1});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_write", i), {write_en, write_x, write_y, write_color},
          {tbl[i].en, tbl[i].ex, tbl[i].ey, tbl[i].ec});
    end

    // Clear with both requesters waiting
    do_reset();
    req0_valid = 1'b1; req0_x = 6'd2; req0_y = 6'd3; req0_color = 12'h321;
    req1_valid = 1'b1; req1_x = 6'd4; req1_y = 6'd5; req1_color = 12'h654;
    clear_start = 1'b1; clear_color = 12'h0A5;
    n_wr = 0; n_done = 0; n_rdy = 0;
    step();
    clear_start = 1'b0; clear_color = 12'h777;
    for (int i = 1; i <= 4096; i++) step();
    chk("clear3_writes", 64'(n_wr), 64'd4096);
    chk("clear3_done_count", 64'(n_done), 64'd1);
    chk("clear3_no_ready", 64'(n_rdy), 64'd0);
    step();
    chk("clear3_post_grant", {rdy0_s, rdy1_s}, 2'b10);

    // Second clear with an ignored clear_start at sweep pixel 100
    clear_start = 1'b1; clear_color = 12'h123;
    n_wr = 0; n_done = 0;
    step();
    clear_start = 1'b0;
    for (int i = 1; i <= 4096; i++) begin
      clear_start = (i == 100);
      clear_color = (i == 100) ? 12'hFFF : 12'h123;
      step();
    end
    clear_start = 1'b0;
    chk("clear4_writes", 64'(n_wr), 64'd4096);
    chk("clear4_done_count", 64'(n_done), 64'd1);

    // Asynchronous reset in the middle of a sweep
    clear_start = 1'b1; clear_color = 12'h5A5;
    step();
    clear_start = 1'b0;
    for (int i = 1; i <= 2000; i++) step();
    chk("mid_sweep_pixel", {write_x, write_y}, {6'd16, 6'd31});
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {write_en, write_x, write_y, write_color, clear_busy, clear_done}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    n_done = 0;
    step();
    chk("after_reset_first_grant", {rdy0_s, rdy1_s}, 2'b10);
    for (int i = 0; i < 20; i++) step();
    chk("after_reset_busy", {29'd0, clear_busy}, 30'd0);
    chk("after_reset_no_done", 64'(n_done), 64'd0);

    // Randomized traffic with one clear and stray clear_start pulses during it
    for (int i = 0; i < 6000; i++) begin
      if (!req0_valid || rdy0_s) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_x = 6'($urandom); req0_y = 6'($urandom); req0_color = 12'($urandom);
      end
      if (!req1_valid || rdy1_s) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_x = 6'($urandom); req1_y = 6'($urandom); req1_color = 12'($urandom);
      end
      clear_color = 12'($urandom);
      clear_start = (i == 1000) || (m_in_clear && ($urandom_range(0, 49) == 0));
      step();
    end
    clear_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
